piso_serializer: RTL and testbench

Parametrised parallel-in/serial-out serializer with a valid/ready load handshake, per-word bit-order select, external shift-enable pacing, and framing flags. It converts `WIDTH`-bit words into a serial bit stream for low-rate serial transmit paths (UART/SPI-style TX front ends). A new word can load in the same cycle the previous word's last bit retires, so back-to-back words stream without gaps. All vacated and idle positions carry a defined fill level.

---
 rtl/piso_pkg.sv | 14 +
 rtl/piso_serializer.sv | 72 +++++++
 tb/tb_piso_serializer.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out serializer.
package piso_pkg;

  typedef enum logic {
    IDLE,
    SHIFT
  } piso_state_t;

  // Bit-counter width for a given word width (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer with valid/ready load, per-word bit order,
// shift-enable pacing and first/last framing flags.
module piso_serializer
  import piso_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter logic        IDLE_LEVEL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_msb_first,
  input  logic             ser_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             frame_first,
  output logic             frame_last,
  output logic             busy
);

  localparam int unsigned      CntW    = cnt_width(WIDTH);
  localparam logic [CntW-1:0]  LastCnt = CntW'(WIDTH - 1);

  piso_state_t      state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CntW-1:0]  cnt_q;
  logic             msb_first_q;
  logic             last_bit;
  logic             accept;

  assign last_bit = (state_q == SHIFT) && (cnt_q == LastCnt);
  // Ready while idle, or as the last bit retires so the next word streams gap-free.
  assign in_ready = (state_q == IDLE) || (last_bit && ser_en);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      shreg_q     <= {WIDTH{IDLE_LEVEL}};
      cnt_q       <= '0;
      msb_first_q <= 1'b1;
    end else if (accept) begin
      state_q     <= SHIFT;
      shreg_q     <= in_data;
      msb_first_q <= in_msb_first;
      cnt_q       <= '0;
    end else if ((state_q == SHIFT) && ser_en) begin
      if (last_bit) begin
        state_q <= IDLE;
        shreg_q <= {WIDTH{IDLE_LEVEL}};
        cnt_q   <= '0;
      end else begin
        if (msb_first_q) begin
          shreg_q <= {shreg_q[WIDTH-2:0], IDLE_LEVEL};
        end else begin
          shreg_q <= {IDLE_LEVEL, shreg_q[WIDTH-1:1]};
        end
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  // Idle and vacated positions hold IDLE_LEVEL, so the output end needs no state gating.
  assign ser_out     = msb_first_q ? shreg_q[WIDTH-1] : shreg_q[0];
  assign ser_valid   = (state_q == SHIFT);
  assign busy        = ser_valid;
  assign frame_first = ser_valid && (cnt_q == '0);
  assign frame_last  = last_bit;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: WIDTH=8/IDLE=1 and WIDTH=3/IDLE=0 instances against a word-level model.
module tb_piso_serializer;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_msb_first;
  logic       ser_en;
  logic [7:0] in_data;
  logic [1:0] in_ready, ser_out, ser_valid, frame_first, frame_last, busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(8), .IDLE_LEVEL(1'b1)) u_w8 (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready[0]),
    .in_data     (in_data),
    .in_msb_first(in_msb_first),
    .ser_en      (ser_en),
    .ser_out     (ser_out[0]),
    .ser_valid   (ser_valid[0]),
    .frame_first (frame_first[0]),
    .frame_last  (frame_last[0]),
    .busy        (busy[0])
  );

  piso_serializer #(.WIDTH(3), .IDLE_LEVEL(1'b0)) u_w3 (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready[1]),
    .in_data     (in_data[2:0]),
    .in_msb_first(in_msb_first),
    .ser_en      (ser_en),
    .ser_out     (ser_out[1]),
    .ser_valid   (ser_valid[1]),
    .frame_first (frame_first[1]),
    .frame_last  (frame_last[1]),
    .busy        (busy[1])
  );

  // Word-level model: a word in flight is (data, order, bit index).
  int         wd[2] = '{8, 3};
  logic       il[2] = '{1'b1, 1'b0};
  logic       m_busy[2];
  int         m_pos[2];
  logic [7:0] m_word[2];
  logic       m_msb[2];
  bit         started = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // {in_ready, ser_valid, busy, ser_out, frame_first, frame_last}
  function automatic logic [5:0] model_out(input int k);
    logic b, last;
    int idx;
    if (!m_busy[k]) return {1'b1, 1'b0, 1'b0, il[k], 1'b0, 1'b0};
    idx  = m_msb[k] ? (wd[k] - 1 - m_pos[k]) : m_pos[k];
    b    = m_word[k][idx];
    last = (m_pos[k] == wd[k] - 1);
    return {last && ser_en, 1'b1, 1'b1, b, m_pos[k] == 0, last};
  endfunction

  always @(posedge clk) begin
    started <= 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_busy[k] <= 1'b0;
        m_pos[k]  <= 0;
      end else if (m_busy[k] && ser_en) begin
        if (m_pos[k] == wd[k] - 1) begin
          if (in_valid) begin
            m_word[k] <= (k == 0) ? in_data : {5'b0, in_data[2:0]};
            m_msb[k]  <= in_msb_first;
            m_pos[k]  <= 0;
          end else begin
            m_busy[k] <= 1'b0;
          end
        end else begin
          m_pos[k] <= m_pos[k] + 1;
        end
      end else if (!m_busy[k] && in_valid) begin
        m_busy[k] <= 1'b1;
        m_word[k] <= (k == 0) ? in_data : {5'b0, in_data[2:0]};
        m_msb[k]  <= in_msb_first;
        m_pos[k]  <= 0;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        check(k == 0 ? "stream_w8" : "stream_w3",
              {26'b0, in_ready[k], ser_valid[k], busy[k], ser_out[k], frame_first[k],
               frame_last[k]},
              {26'b0, model_out(k)});
      end
    end
  end

  task automatic collect(input int k, input int n, output logic [31:0] bits);
    bits = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bits = {bits[30:0], ser_out[k]};
    end
  endtask

  task automatic gap(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] d, input logic msb);
    in_valid     = 1'b1;
    in_data      = d;
    in_msb_first = msb;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  logic [31:0] bits;
  int          rdy_cnt, val_cnt;

  initial begin
    reset        = 1'b1;
    in_valid     = 1'b0;
    in_data      = '0;
    in_msb_first = 1'b1;
    ser_en       = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("reset_out_w8", {31'b0, ser_out[0]}, 32'd1);
    check("reset_out_w3", {31'b0, ser_out[1]}, 32'd0);
    check("reset_ready", {30'b0, in_ready}, 32'd3);
    check("reset_valid", {30'b0, ser_valid}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // A5 MSB-first, continuous enable
    ser_en = 1'b1;
    load(8'hA5, 1'b1);
    collect(0, 8, bits);
    check("a5_msb", bits, 32'hA5);
    @(negedge clk);
    check("a5_after_out", {31'b0, ser_out[0]}, 32'd1);
    check("a5_after_valid", {31'b0, ser_valid[0]}, 32'd0);
    @(posedge clk);
    #1;

    gap(4);
    load(8'hA5, 1'b0);
    collect(0, 8, bits);
    check("a5_lsb", bits, 32'hA5);
    gap(4);
    load(8'h01, 1'b0);
    collect(0, 8, bits);
    check("01_lsb", bits, 32'h80);

    // W3 instance: 3'b110 MSB-first then idle low
    gap(12);
    load(8'h06, 1'b1);
    collect(1, 3, bits);
    check("w3_110", bits, 32'h6);
    @(negedge clk);
    check("w3_idle_out", {31'b0, ser_out[1]}, 32'd0);
    check("w3_idle_valid", {31'b0, ser_valid[1]}, 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back 0F then F0
    gap(12);
    in_valid     = 1'b1;
    in_data      = 8'h0F;
    in_msb_first = 1'b1;
    @(negedge clk);
    rdy_cnt = int'(in_ready[0]);
    val_cnt = 0;
    @(posedge clk);
    #1;
    in_data = 8'hF0;
    bits    = '0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      bits = {bits[30:0], ser_out[0]};
      if (i < 15) rdy_cnt += int'(in_ready[0]);
      val_cnt += int'(ser_valid[0]);
      if (i == 7) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
      end
    end
    check("b2b_bits", bits, 32'h0FF0);
    check("b2b_ready_pulses", rdy_cnt, 32'd2);
    check("b2b_valid_cycles", val_cnt, 32'd16);
    @(posedge clk);
    #1;

    // Paced by ser_en every 4th cycle, in_data churning while not ready
    gap(12);
    ser_en = 1'b0;
    load(8'h3C, 1'b1);
    bits = '0;
    for (int i = 0; i < 32; i++) begin
      ser_en       = (i % 4 == 3);
      in_data      = 8'($urandom);
      in_msb_first = 1'($urandom);
      in_valid     = (i < 28);
      @(negedge clk);
      bits = {bits[30:0], ser_out[0]};
      @(posedge clk);
      #1;
    end
    check("paced_3c", bits, 32'h00FFFF00);

    // Reset mid-word after bit 3 of 3C, then a clean load
    in_valid = 1'b0;
    ser_en   = 1'b1;
    gap(12);
    load(8'h3C, 1'b1);
    collect(0, 4, bits);
    check("rst_prefix", bits, 32'h3);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_out", {31'b0, ser_out[0]}, 32'd1);
    check("rst_valid", {31'b0, ser_valid[0]}, 32'd0);
    check("rst_ready", {31'b0, in_ready[0]}, 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    load(8'hA5, 1'b1);
    @(negedge clk);
    check("rst_reload_first", {31'b0, frame_first[0]}, 32'd1);
    bits = {31'b0, ser_out[0]};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bits = {bits[30:0], ser_out[0]};
    end
    check("rst_reload_a5", bits, 32'hA5);
    @(posedge clk);
    #1;

    // Randomized traffic, checked each cycle by the model compare
    for (int i = 0; i < 3000; i++) begin
      in_valid     = ($urandom_range(0, 3) != 0);
      in_data      = 8'($urandom);
      in_msb_first = 1'($urandom);
      ser_en       = (i < 1500) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 7) == 0);
      reset        = ($urandom_range(0, 199) == 0);
      @(posedge clk);
      #1;
    end
    reset    = 1'b0;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
